// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - two-phase address/data bus sequencer for the external RTC chip
//
// Runs one register read or write per accepted command. Each command is an
// address phase (setup, strobe, hold) followed by a data phase (setup, strobe,
// hold). Every sub-phase lasts PH cycles. A one-cycle done pulse ends the
// command.
//
// Optional feature macro: RTC_TURNAROUND_EN
//   When defined, a PH-cycle TURN state follows DONE. During TURN the chip is
//   deselected and the bus is released before the next command.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   start, rw         command request (sampled only in IDLE); 1 = read, 0 = write
//   addr, wdata       register address and write data, latched with start
//   busy, done        busy in every non-idle state; done pulses one cycle at the end
//   rdata             last byte read, held until the next read completes
//   cs_n, ad_n        chip select (active low); 0 = address phase, 1 = data phase
//   wr_n, rd_n        write / read strobes, active low
//   ad_out, ad_oe     bus value and its output enable (the tristate sits at top level)
//   ad_in             bus value from the pins
module rtc_bus_sequencer #(
  parameter int PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [3:0] PH_M1 = 4'(PH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HLD,
    S_D_SET,
    S_D_STB,
    S_D_HLD,
    S_DONE
`ifdef RTC_TURNAROUND_EN
    , S_TURN
`endif
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       rw_q;
  logic [7:0] wdata_q;

  // Every output is assigned on the edge that enters its state. The pins
  // therefore change together with the state register, and no input reaches
  // a pin combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // ad_out holds the latched address for the whole address phase.
            rw_q    <= rw;
            wdata_q <= wdata;
            state   <= S_A_SET;
            cnt     <= PH_M1;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            ad_n    <= 1'b0;
            ad_oe   <= 1'b1;
            ad_out  <= addr;
          end
        end
        S_DONE: begin
`ifdef RTC_TURNAROUND_EN
          state <= S_TURN;
          cnt   <= PH_M1;
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          // Timed states: the down-counter expires on the last cycle of the state.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            cnt <= PH_M1;
            case (state)
              S_A_SET: begin
                state <= S_A_STB;
                wr_n  <= 1'b0;  // the chip latches the address on a write strobe
              end
              S_A_STB: begin
                state <= S_A_HLD;
                wr_n  <= 1'b1;
              end
              S_A_HLD: begin
                state  <= S_D_SET;
                ad_n   <= 1'b1;
                ad_oe  <= ~rw_q;
                ad_out <= rw_q ? 8'h00 : wdata_q;
              end
              S_D_SET: begin
                state <= S_D_STB;
                if (rw_q) rd_n <= 1'b0;
                else      wr_n <= 1'b0;
              end
              S_D_STB: begin
                // This edge samples ad_in from the last cycle of the read strobe.
                state <= S_D_HLD;
                wr_n  <= 1'b1;
                rd_n  <= 1'b1;
                if (rw_q) rdata <= ad_in;
              end
              S_D_HLD: begin
                state  <= S_DONE;
                done   <= 1'b1;
                cs_n   <= 1'b1;
                ad_oe  <= 1'b0;
                ad_out <= 8'h00;
              end
`ifdef RTC_TURNAROUND_EN
              S_TURN: begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
`endif
              default: begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - randomized self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

`ifdef RTC_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif

  logic            clk;
  logic [1:0]      reset, start, rw;
  logic [1:0][7:0] addr, wdata, ad_in;
  logic [1:0]      busy, done, cs_n, ad_n, wr_n, rd_n, ad_oe;
  logic [1:0][7:0] rdata, ad_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Instance 0 uses PH=2; instance 1 uses PH=1.
  rtc_bus_sequencer #(.PH(2)) dut_ph2 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .rw(rw[0]),
    .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .cs_n(cs_n[0]), .ad_n(ad_n[0]), .wr_n(wr_n[0]),
    .rd_n(rd_n[0]), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in[0])
  );

  rtc_bus_sequencer #(.PH(1)) dut_ph1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .rw(rw[1]),
    .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .cs_n(cs_n[1]), .ad_n(ad_n[1]), .wr_n(wr_n[1]),
    .rd_n(rd_n[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, cs_n, ad_n, wr_n, rd_n, ad_oe;
    logic [7:0] ad_out;
  } pins_t;

  function automatic int ph_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int txn_len(input int ph);
    return 6 * ph + 1 + (TURN ? ph : 0);
  endfunction

  // Pin levels for cycle k of a command (k=0: idle). Sub-phase p = (k-1)/ph
  // runs 0..5: A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD.
  function automatic pins_t expect_pins(input int ph, input int k, input logic r,
                                        input logic [7:0] a, input logic [7:0] w);
    pins_t e;
    int p;
    e = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1,
          rd_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00};
    if (k >= 1 && k <= 6 * ph) begin
      p = (k - 1) / ph;
      e.busy = 1'b1;
      e.cs_n = 1'b0;
      if (p < 3) begin
        e.ad_n   = 1'b0;
        e.ad_oe  = 1'b1;
        e.ad_out = a;
        e.wr_n   = (p == 1) ? 1'b0 : 1'b1;
      end else begin
        e.ad_oe  = ~r;
        e.ad_out = r ? 8'h00 : w;
        if (p == 4) begin
          if (r) e.rd_n = 1'b0;
          else   e.wr_n = 1'b0;
        end
      end
    end else if (k == 6 * ph + 1) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else if (k > 6 * ph + 1) begin
      e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic check8(input string name, input int inst, input logic [7:0] act,
                        input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic checkb(input string name, input int inst, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0b want=%0b", name, inst, cyc, act, exp);
    end
  endtask

  // Reference model: command position k, latched command, and rdata.
  int         mk[2];
  logic       m_rw[2];
  logic [7:0] m_a[2], m_w[2], m_rdata[2];
  bit         armed = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        mk[i]      = 0;
        m_rdata[i] = 8'h00;
      end else if (mk[i] == 0) begin
        if (start[i]) begin
          mk[i]   = 1;
          m_rw[i] = rw[i];
          m_a[i]  = addr[i];
          m_w[i]  = wdata[i];
        end
      end else begin
        if (mk[i] == 5 * ph_of(i) && m_rw[i]) m_rdata[i] = ad_in[i];
        if (mk[i] == txn_len(ph_of(i))) mk[i] = 0;
        else                            mk[i] = mk[i] + 1;
      end
    end
    if (reset == 2'b11) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        pins_t e;
        e = expect_pins(ph_of(i), mk[i], m_rw[i], m_a[i], m_w[i]);
        checkb("busy", i, busy[i], e.busy);
        checkb("done", i, done[i], e.done);
        checkb("cs_n", i, cs_n[i], e.cs_n);
        checkb("ad_n", i, ad_n[i], e.ad_n);
        checkb("wr_n", i, wr_n[i], e.wr_n);
        checkb("rd_n", i, rd_n[i], e.rd_n);
        checkb("ad_oe", i, ad_oe[i], e.ad_oe);
        check8("ad_out", i, ad_out[i], e.ad_out);
        check8("rdata", i, rdata[i], m_rdata[i]);
      end
    end
  end

  initial begin
    int n_done;
    int d1, d2;
    reset = 2'b11; start = '0; rw = '0; addr = '0; wdata = '0; ad_in = '0;
    repeat (3) @(negedge clk);
    reset = 2'b00;
    checkb("lit_rst_busy", 0, busy[0], 1'b0);
    checkb("lit_rst_cs_n", 0, cs_n[0], 1'b1);
    check8("lit_rst_rdata", 0, rdata[0], 8'h00);

    // Write, PH=2: addr 0x21, data 0x45.
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h21; wdata[0] = 8'h45;
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start[0] = 1'b0; addr[0] = 8'hff; wdata[0] = 8'h00;
      if (done[0]) n_done++;
      if (c == 2 || c == 5)  checkb("lit_wr_wr_n_hi", 0, wr_n[0], 1'b1);
      if (c == 3 || c == 4)  checkb("lit_wr_wr_n_lo", 0, wr_n[0], 1'b0);
      if (c == 6)            check8("lit_wr_addr", 0, ad_out[0], 8'h21);
      if (c == 7)            check8("lit_wr_data", 0, ad_out[0], 8'h45);
      if (c == 9 || c == 10) checkb("lit_wr_dstb", 0, wr_n[0], 1'b0);
      if (c == 13)           checkb("lit_wr_done13", 0, done[0], 1'b1);
      if (c == 14) begin
        checkb("lit_wr_busy14", 0, busy[0], 1'b0);
        check8("lit_wr_ndone", 0, 8'(n_done), 8'd1);
      end
    end

    // Read, PH=2: addr 0x23, bus returns 0x37.
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h23; ad_in[0] = 8'h37;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (c == 8)            checkb("lit_rd_oe", 0, ad_oe[0], 1'b0);
      if (c == 9 || c == 10) checkb("lit_rd_rd_n", 0, rd_n[0], 1'b0);
      if (c == 11)           check8("lit_rd_rdata11", 0, rdata[0], 8'h37);
      if (c == 14)           check8("lit_rd_rdata14", 0, rdata[0], 8'h37);
    end

    // Start pulsed in cycle 5 of an active write is dropped.
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h5a; wdata[0] = 8'hc3;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start[0] = (c == 5);
      if (done[0]) n_done++;
    end
    check8("lit_ign_ndone", 0, 8'(n_done), 8'd1);
    checkb("lit_ign_busy", 0, busy[0], 1'b0);

    // Abort: reset in cycles 8..10 of a read.
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h77; ad_in[0] = 8'h99;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      reset[0] = (c >= 8 && c <= 10);
      if (done[0]) n_done++;
      if (c == 9) begin
        checkb("lit_ab_cs_n", 0, cs_n[0], 1'b1);
        checkb("lit_ab_busy", 0, busy[0], 1'b0);
        checkb("lit_ab_oe", 0, ad_oe[0], 1'b0);
        check8("lit_ab_rdata", 0, rdata[0], 8'h00);
      end
    end
    check8("lit_ab_ndone", 0, 8'(n_done), 8'd0);

    // A read after the abort completes normally.
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h12; ad_in[0] = 8'ha5;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (c == 13) checkb("lit_rd2_done", 0, done[0], 1'b1);
      if (c == 14) check8("lit_rd2_rdata", 0, rdata[0], 8'ha5);
    end

    // Back-to-back, PH=1, start held high.
    start[1] = 1'b1; rw[1] = 1'b0; addr[1] = 8'h3c; wdata[1] = 8'h81;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (done[1]) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 8) checkb("lit_b2b_cs8", 1, cs_n[1], 1'b1);
    end
    check8("lit_b2b_done1", 1, 8'(d1), 8'd7);
    check8("lit_b2b_done2", 1, 8'(d2), TURN ? 8'd16 : 8'd15);
    start[1] = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized traffic on both instances, with occasional resets.
    repeat (4000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom % 3) == 0;
        rw[i]    = $urandom % 2;
        addr[i]  = 8'($urandom);
        wdata[i] = 8'($urandom);
        ad_in[i] = 8'($urandom);
        reset[i] = ($urandom % 150) == 0;
      end
    end
    reset = 2'b00; start = 2'b00;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequencer for the external real-time-clock chip's multiplexed address/data bus. The PicoBlaze-side port-decode logic issues single-register read or write commands, and this block drives the RTC strobes and timing for each one. It produces the two-phase cycle: address phase, then data phase. On reads it returns the captured byte. It is the only master of the RTC pins.

## Interface
- PH, 4: cycles per sub-phase (setup, strobe, hold); legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; forces idle state and idle pin levels.
- start  in  1  command request; sampled only while idle.
- rw  in  1  1 = read, 0 = write; sampled with start.
- addr  in  8  RTC register address; sampled with start.
- wdata  in  8  write data; sampled with start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  last read byte; held until next read completes.
- cs_n  out  1  RTC chip select, active low.
- ad_n  out  1  address/data select: 0 = address phase, 1 = data phase.
- wr_n  out  1  write strobe, active low.
- rd_n  out  1  read strobe, active low.
- ad_out  out  8  bus value to drive.
- ad_oe  out  1  1 = drive ad_out onto pins (the tristate sits at top level).
- ad_in  in  8  bus value from pins.

## Operation
- Reset values:
  - busy=0, done=0, rdata=0x00.
  - cs_n=1, ad_n=1, wr_n=1, rd_n=1.
  - ad_out=0x00, ad_oe=0.
  - state=IDLE, phase counter=0.
- Command latch: in IDLE with start=1, latch rw, addr and wdata into internal registers, then go to A_SET. Later input changes have no effect.
- Each timed state lasts exactly PH cycles, counted by a 4-bit down-counter reloaded with PH-1 on entry.
- A_SET: cs_n=0, ad_n=0, ad_oe=1, ad_out=addr.
- A_STB: as A_SET, plus wr_n=0 (address is always latched with a write strobe).
- A_HLD: wr_n=1; address still driven.
- D_SET: ad_n=1.
  - Write: ad_oe=1, ad_out=wdata.
  - Read: ad_oe=0, ad_out=0x00.
- D_STB: as D_SET, plus wr_n=0 (write) or rd_n=0 (read). On a read, rdata<=ad_in at the last cycle of D_STB.
- D_HLD: strobes released; cs_n=0; ad_oe unchanged from D_SET.
- DONE: one cycle. done=1, cs_n=1, ad_n=1, ad_oe=0. Next state is IDLE (or TURN, see Configuration).
- Strobe rule: never assert wr_n and rd_n low in the same cycle. Neither is low outside A_STB and D_STB.
- Start handling:
  - start while busy=1 is ignored; it is not queued.
  - start held high continuously launches back-to-back transactions, each accepted in the IDLE cycle.
- Reset mid-transaction: on the next edge all outputs take their reset values and no done is issued. rdata is cleared.

## Timing
- Define cycle 0 as the IDLE cycle where start=1 is sampled.
- Cycles 1..PH: A_SET. Each following state occupies the next PH cycles.
- D_HLD ends at cycle 6·PH. DONE is cycle 6·PH+1, with done=1.
- Cycle 6·PH+2 is IDLE; a new start can be accepted there.
- Read data is valid on rdata from cycle 5·PH+1 onward, so it is already stable when done is high.
- busy rises in cycle 1 and falls in cycle 6·PH+2.
- PH=1 gives a 7-cycle command-to-done latency. Each strobe is one cycle wide.
- All outputs are registered. There is no combinational path from the inputs to the pins.

## Configuration
- RTC_TURNAROUND_EN:
  - Defined: DONE is followed by a TURN state lasting PH cycles. In TURN, cs_n=1, ad_oe=0, busy=1 and done=0. IDLE is reached at cycle 7·PH+2. This guarantees bus recovery time between back-to-back commands.
  - Undefined: the TURN state does not exist, and DONE goes straight to IDLE.

## Test plan
- Reset check: hold reset 3 cycles mid-stream.
  - Required: cs_n=wr_n=rd_n=ad_n=1, ad_oe=0, busy=0, done=0, rdata=0x00 on the first edge after reset.
- Write, PH=2: start, rw=0, addr=0x21, wdata=0x45 at cycle 0.
  - Cycles 1..6: ad_out=0x21, ad_n=0; wr_n low in cycles 3–4.
  - Cycles 7..12: ad_out=0x45, ad_n=1; wr_n low in cycles 9–10.
  - done=1 exactly at cycle 13; busy=0 at cycle 14.
- Read, PH=2: addr=0x23, ad_in=0x37 during D_STB.
  - ad_oe=0 in cycles 7–12; rd_n low in cycles 9–10; wr_n stays high.
  - rdata=0x37 at cycle 11 and held after done.
- Ignored start: pulse start at cycle 5 of an active write (PH=2).
  - No second transaction; done pulses exactly once.
- Abort: assert reset at cycle 8 of a read.
  - Idle pin levels from cycle 9; no done.
  - A read issued afterwards completes normally.
- Back-to-back: hold start high with PH=1.
  - Macro undefined: done at cycles 7 and 15.
  - RTC_TURNAROUND_EN defined: done at cycles 7 and 16, with cs_n=1 in cycle 8.
